// File: rtl/spw_rx_pkg.sv
// Shared SpaceWire receive-path definitions: control codes, decoder status encodings,
// the NULL alignment pattern and the character decoder FSM state type.
package spw_rx_pkg;

  localparam logic [2:0] CTRL_FCT = 3'd4;
  localparam logic [2:0] CTRL_EOP = 3'd5;
  localparam logic [2:0] CTRL_EEP = 3'd6;
  localparam logic [2:0] CTRL_ESC = 3'd7;

  localparam logic [1:0] SDP_IDLE = 2'd0;
  localparam logic [1:0] SDP_DONE = 2'd1;
  localparam logic [1:0] SDP_ERR  = 2'd2;

  // Oldest bit in the MSB: ESC flag/body (1,1,1), FCT P (0), FCT flag/body (1,0,0)
  localparam logic [6:0] NULL_PATTERN = 7'b1110100;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_PARITY,
    ST_FLAG,
    ST_BODY,
    ST_ERROR
  } rx_state_e;

endpackage

// File: rtl/rx_char_decoder_if.sv
// Bit-stream input and decoded-character output bundle between the bit source and the decoder.
// master = bit source / downstream consumer side, slave = the decoder.
interface rx_char_decoder_if #(
  parameter int DATA_W = 8
);
  logic              bit_in;
  logic              bit_en;
  logic [1:0]        state_data_process;
  logic [2:0]        control;
  logic              last_is_data;
  logic              last_is_control;
  logic              last_is_timec;
  logic [DATA_W:0]   rx_data;
  logic [DATA_W-1:0] rx_timecode;
  logic              rx_got_null;
  logic              rx_got_fct;
  logic              rx_error_parity;
  logic              rx_error_esc;

  modport master (
    output bit_in, bit_en,
    input  state_data_process, control, last_is_data, last_is_control, last_is_timec,
           rx_data, rx_timecode, rx_got_null, rx_got_fct, rx_error_parity, rx_error_esc
  );

  modport slave (
    input  bit_in, bit_en,
    output state_data_process, control, last_is_data, last_is_control, last_is_timec,
           rx_data, rx_timecode, rx_got_null, rx_got_fct, rx_error_parity, rx_error_esc
  );
endinterface

// File: rtl/rx_null_hunt.sv
// Searches the raw bit stream for the first NULL; aligned_o is combinational on the
// enabled bit that completes the pattern, so the caller can switch state on that same edge.
module rx_null_hunt
  import spw_rx_pkg::*;
(
  input  logic negedge_clk,
  input  logic rx_resetn,
  input  logic bit_i,
  input  logic bit_en_i,
  input  logic hunt_en_i,
  output logic aligned_o
);
  logic [5:0] sr_q;
  logic [6:0] window_d;

  assign window_d  = {sr_q, bit_i};
  assign aligned_o = bit_en_i && hunt_en_i && (window_d == NULL_PATTERN);

  always_ff @(posedge negedge_clk or negedge rx_resetn) begin
    if (!rx_resetn) begin
      sr_q <= '0;
    end else if (bit_en_i && hunt_en_i) begin
      sr_q <= window_d[5:0];
    end
  end
endmodule

// File: rtl/rx_char_decoder.sv
// SpaceWire RX character decoder: aligns on the first NULL, then assembles, parity-checks and
// classifies characters; all outputs are registered one cycle after the last body bit.
module rx_char_decoder
  import spw_rx_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic             negedge_clk,
  input  logic             rx_resetn,
  rx_char_decoder_if.slave rx_if
);
  rx_state_e         state_q;
  logic [3:0]        cnt_q;
  logic [DATA_W-1:0] byte_q;
  logic              is_ctrl_q;
  logic              par_q;
  logic              par_err_q;
  logic              acc_q;
  logic              esc_q;

  logic [1:0]        sdp_q;
  logic [2:0]        control_q;
  logic              last_data_q;
  logic              last_ctrl_q;
  logic              last_timec_q;
  logic [DATA_W:0]   rx_data_q;
  logic [DATA_W-1:0] timecode_q;
  logic              got_null_q;
  logic              got_fct_q;
  logic              err_par_q;
  logic              err_esc_q;

  logic              aligned;
  logic [DATA_W-1:0] byte_d;
  logic [2:0]        ctrl_d;
  logic              esc_err_d;

  rx_null_hunt u_null_hunt (
    .negedge_clk (negedge_clk),
    .rx_resetn   (rx_resetn),
    .bit_i       (rx_if.bit_in),
    .bit_en_i    (rx_if.bit_en),
    .hunt_en_i   (state_q == ST_HUNT),
    .aligned_o   (aligned)
  );

  // Body bits arrive LSB first, so they shift in from the top of the byte register
  assign byte_d    = {rx_if.bit_in, byte_q[DATA_W-1:1]};
  assign ctrl_d    = {1'b1, rx_if.bit_in, byte_q[DATA_W-1]};
  assign esc_err_d = esc_q && (ctrl_d != CTRL_FCT);

  always_ff @(posedge negedge_clk or negedge rx_resetn) begin
    if (!rx_resetn) begin
      state_q      <= ST_HUNT;
      cnt_q        <= '0;
      byte_q       <= '0;
      is_ctrl_q    <= 1'b0;
      par_q        <= 1'b0;
      par_err_q    <= 1'b0;
      acc_q        <= 1'b0;
      esc_q        <= 1'b0;
      sdp_q        <= SDP_IDLE;
      control_q    <= '0;
      last_data_q  <= 1'b0;
      last_ctrl_q  <= 1'b0;
      last_timec_q <= 1'b0;
      rx_data_q    <= '0;
      timecode_q   <= '0;
      got_null_q   <= 1'b0;
      got_fct_q    <= 1'b0;
      err_par_q    <= 1'b0;
      err_esc_q    <= 1'b0;
    end else begin
      got_null_q <= 1'b0;
      got_fct_q  <= 1'b0;
      err_par_q  <= 1'b0;
      err_esc_q  <= 1'b0;
      if (state_q != ST_ERROR) sdp_q <= SDP_IDLE;

      if (rx_if.bit_en) begin
        case (state_q)
          ST_HUNT: begin
            if (aligned) begin
              got_null_q <= 1'b1;
              acc_q      <= 1'b0;
              esc_q      <= 1'b0;
              state_q    <= ST_PARITY;
            end
          end
          ST_PARITY: begin
            par_q   <= rx_if.bit_in ^ acc_q;
            state_q <= ST_FLAG;
          end
          ST_FLAG: begin
            // Odd parity across P, previous body and this flag; flagged now, reported at char end
            par_err_q <= ~(par_q ^ rx_if.bit_in);
            is_ctrl_q <= rx_if.bit_in;
            cnt_q     <= rx_if.bit_in ? 4'd2 : 4'(DATA_W);
            acc_q     <= 1'b0;
            state_q   <= ST_BODY;
          end
          ST_BODY: begin
            byte_q <= byte_d;
            acc_q  <= acc_q ^ rx_if.bit_in;
            cnt_q  <= cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
              if (par_err_q || (is_ctrl_q && esc_err_d)) begin
                err_par_q <= par_err_q;
                err_esc_q <= is_ctrl_q && esc_err_d;
                sdp_q     <= SDP_ERR;
                state_q   <= ST_ERROR;
              end else begin
                state_q <= ST_PARITY;
                if (!is_ctrl_q) begin
                  sdp_q        <= SDP_DONE;
                  last_data_q  <= !esc_q;
                  last_timec_q <= esc_q;
                  last_ctrl_q  <= 1'b0;
                  esc_q        <= 1'b0;
                  if (esc_q) timecode_q <= byte_d;
                  else       rx_data_q  <= {1'b0, byte_d};
                end else begin
                  case (ctrl_d)
                    CTRL_FCT: begin
                      if (esc_q) begin
                        got_null_q <= 1'b1;
                        esc_q      <= 1'b0;
                      end else begin
                        got_fct_q    <= 1'b1;
                        sdp_q        <= SDP_DONE;
                        control_q    <= CTRL_FCT;
                        last_ctrl_q  <= 1'b1;
                        last_data_q  <= 1'b0;
                        last_timec_q <= 1'b0;
                      end
                    end
                    CTRL_EOP, CTRL_EEP: begin
                      sdp_q        <= SDP_DONE;
                      control_q    <= ctrl_d;
                      last_ctrl_q  <= 1'b1;
                      last_data_q  <= 1'b0;
                      last_timec_q <= 1'b0;
                      rx_data_q    <= {1'b1, {(DATA_W-1){1'b0}}, (ctrl_d == CTRL_EEP)};
                    end
                    default: begin
                      esc_q     <= 1'b1;
                      control_q <= CTRL_ESC;
                    end
                  endcase
                end
              end
            end
          end
          ST_ERROR: ;
          default: state_q <= ST_ERROR;
        endcase
      end
    end
  end

  assign rx_if.state_data_process = sdp_q;
  assign rx_if.control            = control_q;
  assign rx_if.last_is_data       = last_data_q;
  assign rx_if.last_is_control    = last_ctrl_q;
  assign rx_if.last_is_timec      = last_timec_q;
  assign rx_if.rx_data            = rx_data_q;
  assign rx_if.rx_timecode        = timecode_q;
  assign rx_if.rx_got_null        = got_null_q;
  assign rx_if.rx_got_fct         = got_fct_q;
  assign rx_if.rx_error_parity    = err_par_q;
  assign rx_if.rx_error_esc       = err_esc_q;
endmodule
